stack_replayer: RTL and testbench
=================================

Name: stack_replayer

Overview:
- Initiator/client for the team's 2-bit-wide Push/Pop stack.
- Accepts a terminated stream of 2-bit symbols (valid/ready) and pushes each one onto the external stack.
- After the last symbol it pops the stack and replays the symbols in reverse order on a valid/ready output stream.
- Sits between a path/symbol producer and a downstream consumer; owns all stack command sequencing.

Parameters:
- W, 2: symbol width; must match stack data width.
- DEPTH, 255: maximum symbols stored; must not exceed the stack's usable capacity.
- SETTLE, 2: idle cycles after each stack command before stack outputs (Top/Empty/Full) are sampled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  W  input symbol.
- in_last  in  1  qualifies in_data as the final symbol of the sequence.
- out_valid  out  1  replay symbol valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  replay symbol.
- out_last  out  1  marks the final replay symbol.
- stk_push  out  1  stack push command, 1-cycle pulse.
- stk_pop  out  1  stack pop command, 1-cycle pulse.
- stk_din  out  W  stack push data.
- stk_full  in  1  stack full flag.
- stk_empty  in  1  stack empty flag.
- stk_top  in  W  stack top-of-stack.
- count  out  clog2(DEPTH+1)  symbols currently held.
- busy  out  1  high in any state other than LOAD.
- overflow  out  1  sticky: a symbol was dropped.
- mismatch  out  1  sticky: stk_empty disagreed with count at a sample point.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. The external stack must be reset by the same rst.
- Reset values: state=LOAD, count=0, in_ready=1, out_valid=0, out_last=0, out_data=0, stk_push=0, stk_pop=0, stk_din=0, overflow=0, mismatch=0, busy=0.
- Reset mid-operation: any state returns to LOAD next cycle with all reset values; in-flight symbols are discarded.
- States: LOAD, PSETTLE, REPLAY_WAIT, PRESENT, DONE.
- LOAD: in_ready=1. On in_valid handshake:
  - If count<DEPTH and stk_full=0: stk_push=1 and stk_din=in_data in the following cycle (registered); count+1.
  - Otherwise the symbol is dropped and overflow is set; no push is issued.
  - Next state is PSETTLE. in_last is latched into last_seen.
- PSETTLE: in_ready=0 for SETTLE cycles, driven by a down-counter. Then:
  - last_seen=0: go to LOAD.
  - last_seen=1: go to REPLAY_WAIT.
  - Throughput is one symbol per SETTLE+1 cycles minimum.
- REPLAY_WAIT: holds for SETTLE cycles, then samples the stack.
  - Set mismatch if stk_empty != (count==0).
  - count==0: go to DONE.
  - Otherwise: out_data=stk_top, out_last=(count==1), out_valid=1, go to PRESENT.
- PRESENT: out_valid, out_data and out_last are held stable until out_ready=1.
  - On the handshake: out_valid=0, stk_pop=1 for exactly one cycle, count-1, go to REPLAY_WAIT.
- DONE: 1-cycle state, then LOAD. overflow and mismatch stay set until rst.
- Command rules:
  - stk_push and stk_pop are never asserted in the same cycle.
  - At most one command per SETTLE+1 cycles.
  - Pop is never issued when count==0; push is never issued when count==DEPTH.
- Data ordering: the replay order is the exact reverse of the accepted, non-dropped input order.
- Overflow case: dropped symbols are excluded from the replay. out_last still marks the deepest stored symbol.
- Single-symbol sequence (in_last on the first symbol): exactly one output beat, with out_last=1.
- count width uses unsigned arithmetic. count never wraps; the saturation guard is in LOAD.

Decomposition:
- Package stack_pkg:
  - Typedef `state_t` enum {LOAD, PSETTLE, REPLAY_WAIT, PRESENT, DONE}.
  - Constant STK_W=2.
  - Constant STK_DEPTH=255.
  - Typedef `sym_t` = logic [STK_W-1:0].
- Sub-module settle_timer: loadable down-counter with a `done` pulse, parameterised by SETTLE. It is shared by PSETTLE and REPLAY_WAIT.
- The FSM, count and flags stay in stack_replayer.

Test Plan:
- Push sequence 1,2,3,0 (last on 0), out_ready=1 → out_data 0,3,2,1; out_last only on 1; count 4→0; pushes spaced ≥SETTLE+1 cycles apart; no push/pop overlap.
- Single symbol 2 with in_last → one beat, out_data=2, out_last=1, then LOAD with in_ready=1.
- Backpressure: sequence 3,1; out_ready held 0 for 10 cycles → out_valid=1 and out_data=1 stable; stk_pop not asserted until the handshake.
- DEPTH=3, send 0,1,2,3 (last on 3) → 3 dropped, overflow=1, replay 2,1,0, out_last on 0.
- rst asserted in PRESENT after 2 of 4 replays → next cycle in_ready=1, count=0, out_valid=0; new sequence 1,1 replays as 1,1 with the stack also reset.
- Model stk_empty forced 0 while count==0 at the final sample → mismatch=1 and stays set; DONE is still reached.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack replayer and its stack partner.
//   state_t   : replayer FSM states
//   STK_W     : stack data width
//   STK_DEPTH : usable stack capacity
//   sym_t     : one stack symbol
package stack_pkg;

    localparam int STK_W     = 2;
    localparam int STK_DEPTH = 255;

    typedef logic [STK_W-1:0] sym_t;

    typedef enum logic [2:0] {
        LOAD,
        PSETTLE,
        REPLAY_WAIT,
        PRESENT,
        DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that marks the end of a stack settle window.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the window (counter := SETTLE)
//   done     : high in the last cycle of the window
// The window is SETTLE cycles long, counted from the cycle after load.
// SETTLE must be at least 1.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int TW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(SETTLE);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == TW'(1));

endmodule

// File: rtl/stack_replayer.sv
// Pushes a terminated symbol stream onto an external push/pop stack, then
// pops it back out and replays the symbols in reverse order.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last     : input symbol stream
//   out_valid/out_ready/out_data/out_last : reversed replay stream
//   stk_push/stk_pop/stk_din      : stack commands (one-cycle pulses)
//   stk_full/stk_empty/stk_top    : stack status, sampled after SETTLE cycles
//   count    : symbols currently held on the stack
//   busy     : not in LOAD
//   overflow : sticky, a symbol was dropped
//   mismatch : sticky, stk_empty disagreed with count at a sample point
module stack_replayer
    import stack_pkg::*;
#(
    parameter int W      = STK_W,
    parameter int DEPTH  = STK_DEPTH,
    parameter int SETTLE = 2,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [W-1:0]  stk_din,
    input  logic          stk_full,
    input  logic          stk_empty,
    input  logic [W-1:0]  stk_top,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          overflow,
    output logic          mismatch
);

    state_t        state, state_n;
    logic [CW-1:0] count_n;
    logic          last_seen, last_seen_n;
    logic          out_valid_n, out_last_n;
    logic [W-1:0]  out_data_n, stk_din_n;
    logic          stk_push_n, stk_pop_n;
    logic          overflow_n, mismatch_n;
    logic          tmr_load, tmr_done;

    // One timer serves both settle windows; they never overlap.
    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .done (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            count     <= '0;
            last_seen <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_din   <= '0;
            overflow  <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            last_seen <= last_seen_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            stk_push  <= stk_push_n;
            stk_pop   <= stk_pop_n;
            stk_din   <= stk_din_n;
            overflow  <= overflow_n;
            mismatch  <= mismatch_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        last_seen_n = last_seen;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_last_n  = out_last;
        stk_push_n  = 1'b0;
        stk_pop_n   = 1'b0;
        stk_din_n   = stk_din;
        overflow_n  = overflow;
        mismatch_n  = mismatch;
        tmr_load    = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    last_seen_n = in_last;
                    tmr_load    = 1'b1;
                    state_n     = PSETTLE;
                    // Saturation guard: count can never exceed DEPTH.
                    if (count < CW'(DEPTH) && !stk_full) begin
                        stk_push_n = 1'b1;
                        stk_din_n  = in_data;
                        count_n    = count + 1'b1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
            end
            PSETTLE: begin
                if (tmr_done) begin
                    if (last_seen) begin
                        tmr_load = 1'b1;
                        state_n  = REPLAY_WAIT;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            REPLAY_WAIT: begin
                if (tmr_done) begin
                    if (stk_empty != (count == '0)) mismatch_n = 1'b1;
                    if (count == '0) begin
                        state_n = DONE;
                    end else begin
                        out_valid_n = 1'b1;
                        out_data_n  = stk_top;
                        out_last_n  = (count == CW'(1));
                        state_n     = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    stk_pop_n   = 1'b1;
                    count_n     = count - 1'b1;
                    tmr_load    = 1'b1;
                    state_n     = REPLAY_WAIT;
                end
            end
            DONE:    state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

endmodule

// File: tb/tb_stack_replayer.sv
module tb_stack_replayer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;       // 0: DEPTH=255 instance, 1: DEPTH=3 instance
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [1:0] in_data = 2'd0;
    logic       out_ready = 1'b1;
    logic       force_ne = 1'b0;  // forces stk_empty low on instance a

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instance a
    logic       in_ready_a, out_valid_a, out_last_a, stk_push_a, stk_pop_a;
    logic       busy_a, overflow_a, mismatch_a, stk_full_a, stk_empty_a;
    logic [1:0] out_data_a, stk_din_a, stk_top_a;
    logic [7:0] count_a;
    // instance b
    logic       in_ready_b, out_valid_b, out_last_b, stk_push_b, stk_pop_b;
    logic       busy_b, overflow_b, mismatch_b, stk_full_b, stk_empty_b;
    logic [1:0] out_data_b, stk_din_b, stk_top_b;
    logic [1:0] count_b;

    stack_replayer #(.W(2), .DEPTH(255), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
        .stk_push(stk_push_a), .stk_pop(stk_pop_a), .stk_din(stk_din_a),
        .stk_full(stk_full_a), .stk_empty(stk_empty_a), .stk_top(stk_top_a),
        .count(count_a), .busy(busy_a), .overflow(overflow_a), .mismatch(mismatch_a)
    );

    stack_replayer #(.W(2), .DEPTH(3), .SETTLE(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
        .stk_push(stk_push_b), .stk_pop(stk_pop_b), .stk_din(stk_din_b),
        .stk_full(stk_full_b), .stk_empty(stk_empty_b), .stk_top(stk_top_b),
        .count(count_b), .busy(busy_b), .overflow(overflow_b), .mismatch(mismatch_b)
    );

    // Stack models, 16 entries each, reset by the same rst.
    logic [1:0] mem_a [16];
    logic [1:0] mem_b [16];
    logic [4:0] sp_a, sp_b;

    always @(posedge clk) begin
        if (rst) sp_a <= 5'd0;
        else if (stk_push_a && sp_a < 5'd16) begin mem_a[sp_a[3:0]] <= stk_din_a; sp_a <= sp_a + 5'd1; end
        else if (stk_pop_a && sp_a > 5'd0) sp_a <= sp_a - 5'd1;
        if (rst) sp_b <= 5'd0;
        else if (stk_push_b && sp_b < 5'd16) begin mem_b[sp_b[3:0]] <= stk_din_b; sp_b <= sp_b + 5'd1; end
        else if (stk_pop_b && sp_b > 5'd0) sp_b <= sp_b - 5'd1;
    end

    logic [4:0] spm_a, spm_b;
    assign spm_a       = sp_a - 5'd1;
    assign spm_b       = sp_b - 5'd1;
    assign stk_top_a   = (sp_a != 5'd0) ? mem_a[spm_a[3:0]] : 2'd0;
    assign stk_top_b   = (sp_b != 5'd0) ? mem_b[spm_b[3:0]] : 2'd0;
    assign stk_empty_a = (sp_a == 5'd0) & ~force_ne;
    assign stk_empty_b = (sp_b == 5'd0);
    assign stk_full_a  = (sp_a == 5'd16);
    assign stk_full_b  = (sp_b == 5'd16);

    // Selected-instance views
    logic       in_ready_s, out_valid_s, out_last_s, push_s, pop_s, busy_s;
    logic [1:0] out_data_s;
    assign in_ready_s  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_s = sel ? out_valid_b : out_valid_a;
    assign out_last_s  = sel ? out_last_b  : out_last_a;
    assign out_data_s  = sel ? out_data_b  : out_data_a;
    assign push_s      = sel ? stk_push_b  : stk_push_a;
    assign pop_s       = sel ? stk_pop_b   : stk_pop_a;
    assign busy_s      = sel ? busy_b      : busy_a;

    // Output beat capture: {last, data}
    logic [2:0] cap_q [$];
    always @(posedge clk)
        if (!rst && out_valid_s && out_ready) cap_q.push_back({out_last_s, out_data_s});

    // Command-rule monitor
    int cyc = 0;
    int last_cmd = -100;
    int viol_overlap = 0;
    int viol_space = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) last_cmd <= -100;
        else if (push_s || pop_s) begin
            if (push_s && pop_s) viol_overlap <= viol_overlap + 1;
            if (cyc - last_cmd < 3) viol_space <= viol_space + 1;
            last_cmd <= cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        cap_q.delete();
    endtask

    task automatic send(input logic [1:0] d, input logic l);
        int n = 0;
        @(negedge clk); in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready_s && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready_s);
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_caps(input int num);
        int n = 0;
        while (cap_q.size() < num && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL beat_timeout beats=%0d required %0d", cap_q.size(), num);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_s && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy=%0b required 0", busy_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready_a, out_valid_a, out_last_a, stk_push_a, stk_pop_a, busy_a} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got %b required 100000",
                {in_ready_a, out_valid_a, out_last_a, stk_push_a, stk_pop_a, busy_a});
        end
        checks++;
        if ({count_a, out_data_a, stk_din_a, overflow_a, mismatch_a} !== 14'd0) begin
            errors++; $display("FAIL reset_data count=%0d out_data=%0d din=%0d ovf=%0b mis=%0b required all 0",
                count_a, out_data_a, stk_din_a, overflow_a, mismatch_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] exp [4];
        exp[0] = 3'b000; exp[1] = 3'b011; exp[2] = 3'b010; exp[3] = 3'b101;
        sel = 1'b0; out_ready = 1'b1; cap_q.delete();
        send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b1);
        checks++;
        if (count_a !== 8'd4) begin errors++; $display("FAIL basic_count got %0d required 4", count_a); end
        checks++;
        if ({stk_push_a, stk_din_a} !== 3'b100) begin
            errors++; $display("FAIL basic_last_push push=%0b din=%0d required 1,0", stk_push_a, stk_din_a);
        end
        wait_caps(4);
        checks++;
        if (cap_q.size() != 4) begin errors++; $display("FAIL basic_beats got %0d required 4", cap_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_q[i] !== exp[i]) begin
                errors++; $display("FAIL basic_beat%0d got last=%0b data=%0d required last=%0b data=%0d",
                    i, cap_q[i][2], cap_q[i][1:0], exp[i][2], exp[i][1:0]);
            end
        end
        wait_idle();
        checks++;
        if (count_a !== 8'd0) begin errors++; $display("FAIL basic_end_count got %0d required 0", count_a); end
        checks++;
        if (viol_space != 0 || viol_overlap != 0) begin
            errors++; $display("FAIL basic_cmd_rules spacing=%0d overlap=%0d required 0,0", viol_space, viol_overlap);
        end
    endtask

    task automatic test_single();
        sel = 1'b0; out_ready = 1'b1; cap_q.delete();
        send(2'd2, 1'b1);
        wait_caps(1);
        wait_idle();
        checks++;
        if (cap_q.size() != 1 || cap_q[0] !== 3'b110) begin
            errors++; $display("FAIL single_beat beats=%0d first=%b required 1 beat 110", cap_q.size(), cap_q[0]);
        end
        checks++;
        if ({in_ready_a, busy_a} !== 2'b10) begin
            errors++; $display("FAIL single_load in_ready=%0b busy=%0b required 1,0", in_ready_a, busy_a);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        sel = 1'b0; out_ready = 1'b0; cap_q.delete();
        send(2'd3, 1'b0); send(2'd1, 1'b1);
        while (!out_valid_a && n < 100) begin @(negedge clk); n++; end
        repeat (10) begin
            if (!out_valid_a || out_data_a !== 2'd1 || out_last_a !== 1'b0 || stk_pop_a) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold bad_cycles=%0d required 0 (valid=%0b data=%0d pop=%0b)",
                bad, out_valid_a, out_data_a, stk_pop_a);
        end
        out_ready = 1'b1;
        wait_caps(2);
        checks++;
        if (cap_q.size() != 2 || cap_q[0] !== 3'b001 || cap_q[1] !== 3'b111) begin
            errors++; $display("FAIL bp_order beats=%0d b0=%b b1=%b required 001,111",
                cap_q.size(), cap_q[0], cap_q[1]);
        end
        wait_idle();
    endtask

    task automatic test_overflow();
        sel = 1'b1; out_ready = 1'b1; cap_q.delete();
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b1);
        checks++;
        if ({overflow_b, stk_push_b, count_b} !== 4'b1011) begin
            errors++; $display("FAIL ovf_drop ovf=%0b push=%0b count=%0d required 1,0,3",
                overflow_b, stk_push_b, count_b);
        end
        wait_caps(3);
        wait_idle();
        checks++;
        if (cap_q.size() != 3 || cap_q[0] !== 3'b010 || cap_q[1] !== 3'b001 || cap_q[2] !== 3'b100) begin
            errors++; $display("FAIL ovf_replay beats=%0d b0=%b b1=%b b2=%b required 010,001,100",
                cap_q.size(), cap_q[0], cap_q[1], cap_q[2]);
        end
        checks++;
        if (overflow_b !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b required 1", overflow_b); end
        sel = 1'b0;
    endtask

    task automatic test_midreset();
        int n;
        sel = 1'b0; out_ready = 1'b0; cap_q.delete();
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!out_valid_a && n < 100) begin @(negedge clk); n++; end
            out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
        end
        n = 0;
        while (!out_valid_a && n < 100) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_a, out_valid_a, count_a} !== 10'b10_0000_0000) begin
            errors++; $display("FAIL midrst_state in_ready=%0b out_valid=%0b count=%0d required 1,0,0",
                in_ready_a, out_valid_a, count_a);
        end
        rst = 1'b0; out_ready = 1'b1; cap_q.delete();
        send(2'd1, 1'b0); send(2'd1, 1'b1);
        wait_caps(2);
        wait_idle();
        checks++;
        if (cap_q.size() != 2 || cap_q[0] !== 3'b001 || cap_q[1] !== 3'b101) begin
            errors++; $display("FAIL midrst_replay beats=%0d b0=%b b1=%b required 001,101",
                cap_q.size(), cap_q[0], cap_q[1]);
        end
        checks++;
        if ({mismatch_a, count_a} !== 9'd0) begin
            errors++; $display("FAIL midrst_stack mismatch=%0b count=%0d required 0,0", mismatch_a, count_a);
        end
    endtask

    task automatic test_mismatch();
        sel = 1'b0; out_ready = 1'b1; cap_q.delete(); force_ne = 1'b1;
        send(2'd2, 1'b1);
        wait_caps(1);
        wait_idle();
        checks++;
        if (mismatch_a !== 1'b1) begin errors++; $display("FAIL mis_set got %0b required 1", mismatch_a); end
        checks++;
        if (cap_q.size() != 1 || cap_q[0] !== 3'b110) begin
            errors++; $display("FAIL mis_beat beats=%0d first=%b required 110", cap_q.size(), cap_q[0]);
        end
        force_ne = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({mismatch_a, busy_a, in_ready_a} !== 3'b101) begin
            errors++; $display("FAIL mis_sticky mismatch=%0b busy=%0b in_ready=%0b required 1,0,1",
                mismatch_a, busy_a, in_ready_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overflow();
        do_reset();
        test_midreset();
        test_mismatch();
        checks++;
        if (viol_space != 0 || viol_overlap != 0) begin
            errors++; $display("FAIL cmd_rules spacing=%0d overlap=%0d required 0,0", viol_space, viol_overlap);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
